mmio_peripherals: RTL and testbench

//  Memory-mapped peripheral block on the MEM stage's data bus, alongside DataMemory. It decodes the
//  0x4000_00xx window and holds a reloadable timer with interrupt, LED and 7-segment display registers,
//  and a free-running systick. Reads are combinational; the CPU muxes rdata with DataMemory data using hit.

---
 rtl/mmio_pkg.sv | 40 ++++
 rtl/mmio_peripherals_seg7_scan.sv | 51 +++++
 rtl/mmio_peripherals.sv | 127 ++++++++++++
 tb/tb_mmio_peripherals.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared address map, TCON bit positions and 7-segment decode for the MMIO peripheral block.
package mmio_pkg;

   localparam logic [23:0] MMIO_BASE   = 24'h400000;
   localparam logic [7:0]  OFF_TH      = 8'h00;
   localparam logic [7:0]  OFF_TL      = 8'h04;
   localparam logic [7:0]  OFF_TCON    = 8'h08;
   localparam logic [7:0]  OFF_LED     = 8'h0C;
   localparam logic [7:0]  OFF_DIGI    = 8'h10;
   localparam logic [7:0]  OFF_SYSTICK = 8'h14;

   localparam int TC_EN = 0;
   localparam int TC_IE = 1;
   localparam int TC_IP = 2;

   // Common-anode segments {dp,g,f,e,d,c,b,a}, active low; dp is always dark.
   function automatic logic [7:0] seg7_decode(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         default: seg = 8'h8E;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/mmio_peripherals_seg7_scan.sv
// Multiplexed 4-digit 7-segment driver: prescaled digit rotation with a registered segment decode.
module seg7_scan
   import mmio_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV = 16'd50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   output logic [3:0]  an,
   output logic [7:0]  seg
);

   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  seg_q, seg_d;
   logic [3:0]  nib [4];

   for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = value[gi*4 +: 4];
   end

   // Segments are only reloaded on a slot boundary, so a new value never
   // alters the digit currently being shown.
   always_comb begin
      cnt_d = cnt_q + 16'd1;
      idx_d = idx_q;
      seg_d = seg_q;
      if (cnt_q == SCAN_DIV - 16'd1) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
         seg_d = seg7_decode(nib[idx_d]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
         seg_q <= seg7_decode(4'h0);
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
      end
   end

   assign an  = ~(4'b0001 << idx_q);
   assign seg = seg_q;

endmodule

// File: rtl/mmio_peripherals.sv
// MEM-stage peripheral window at 0x4000_00xx: reload timer with interrupt, LEDs, 7-seg and systick.
module mmio_peripherals
   import mmio_pkg::*;
#(
   parameter logic [15:0] SCAN_DIV = 16'd50000,
   parameter int          LED_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic [31:0]      rdata,
   output logic             hit,
   output logic             irq,
   output logic [LED_W-1:0] leds,
   output logic [3:0]       digi_an,
   output logic [7:0]       digi_seg,
   output logic [31:0]      systick
);

   logic [31:0]      th_q, th_d;
   logic [31:0]      tl_q, tl_d;
   logic [2:0]       tcon_q, tcon_d;
   logic [LED_W-1:0] leds_q, leds_d;
   logic [15:0]      digi_q, digi_d;
   logic [31:0]      systick_q;

   logic [7:0]  off;
   logic        wr_en;
   logic        ovf;
   logic        ovf_set;
   logic [31:0] led_ext;
   logic        unused_addr_lsb;

   assign hit             = (addr[31:8] == MMIO_BASE);
   assign off             = {addr[7:2], 2'b00};
   assign wr_en           = hit & mem_write;
   assign unused_addr_lsb = ^addr[1:0];

   assign ovf     = tcon_q[TC_EN] && (tl_q == 32'hFFFF_FFFF);
   assign ovf_set = ovf & tcon_q[TC_IE];

   always_comb begin
      th_d   = th_q;
      tl_d   = tl_q;
      tcon_d = tcon_q;
      leds_d = leds_q;
      digi_d = digi_q;

      if (tcon_q[TC_EN]) begin
         tl_d = ovf ? th_q : tl_q + 32'd1;
      end
      tcon_d[TC_IP] = tcon_q[TC_IP] | ovf_set;

      // CPU stores override the timer's own update of TL; a pending bit can
      // only be cleared by software and a coincident overflow still lands.
      if (wr_en) begin
         case (off)
            OFF_TH:   th_d = wdata;
            OFF_TL:   tl_d = wdata;
            OFF_TCON: begin
               tcon_d[TC_EN] = wdata[TC_EN];
               tcon_d[TC_IE] = wdata[TC_IE];
               tcon_d[TC_IP] = ovf_set | (tcon_q[TC_IP] & wdata[TC_IP]);
            end
            OFF_LED:  leds_d = wdata[LED_W-1:0];
            OFF_DIGI: digi_d = wdata[15:0];
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         th_q      <= '0;
         tl_q      <= '0;
         tcon_q    <= '0;
         leds_q    <= '0;
         digi_q    <= '0;
         systick_q <= '0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         leds_q    <= leds_d;
         digi_q    <= digi_d;
         systick_q <= systick_q + 32'd1;
      end
   end

   always_comb begin
      led_ext              = '0;
      led_ext[LED_W-1:0]   = leds_q;
   end

   always_comb begin
      rdata = '0;
      if (hit && mem_read) begin
         case (off)
            OFF_TH:      rdata = th_q;
            OFF_TL:      rdata = tl_q;
            OFF_TCON:    rdata = {29'b0, tcon_q};
            OFF_LED:     rdata = led_ext;
            OFF_DIGI:    rdata = {16'b0, digi_q};
            OFF_SYSTICK: rdata = systick_q;
            default:     rdata = '0;
         endcase
      end
   end

   seg7_scan #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk   (clk),
      .rst   (rst),
      .value (digi_q),
      .an    (digi_an),
      .seg   (digi_seg)
   );

   assign irq     = tcon_q[TC_IP];
   assign leds    = leds_q;
   assign systick = systick_q;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Self-checking bench for mmio_peripherals: vector table, directed timer/scan sequences, random traffic.
module tb_mmio_peripherals;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] rdata;
   logic        hit;
   logic        irq;
   logic [7:0]  leds;
   logic [3:0]  digi_an;
   logic [7:0]  digi_seg;
   logic [31:0] systick;

   mmio_peripherals #(
      .SCAN_DIV (16'(SD)),
      .LED_W    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .wdata     (wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .rdata     (rdata),
      .hit       (hit),
      .irq       (irq),
      .leds      (leds),
      .digi_an   (digi_an),
      .digi_seg  (digi_seg),
      .systick   (systick)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] dec_tab [16];

   // reference state
   logic [31:0] m_th, m_tl, m_tick, m_digi;
   logic [2:0]  m_tcon;
   logic [7:0]  m_led, m_seg;
   int          m_cyc;

   typedef struct {
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] ra;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic in_window(input logic [31:0] a);
      return a[31:8] == 24'h400000;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (!in_window(a)) return 32'h0;
      case (a[7:2])
         6'd0:    return m_th;
         6'd1:    return m_tl;
         6'd2:    return {29'b0, m_tcon};
         6'd3:    return {24'b0, m_led};
         6'd4:    return {16'b0, m_digi[15:0]};
         6'd5:    return m_tick;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      logic        overflow;
      logic        ip_set;
      logic [31:0] n_tl;
      logic [2:0]  n_tcon;
      int          slot;
      if (r) begin
         m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
         m_cyc = 0; m_seg = dec_tab[0];
         return;
      end
      overflow = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
      ip_set   = overflow && m_tcon[1];
      n_tl     = m_tcon[0] ? (overflow ? m_th : m_tl + 1) : m_tl;
      n_tcon   = {m_tcon[2] | ip_set, m_tcon[1:0]};
      m_cyc++;
      if (m_cyc % SD == 0) begin
         slot  = (m_cyc / SD) % 4;
         m_seg = dec_tab[(m_digi >> (4 * slot)) & 32'hF];
      end
      m_tick++;
      if (w && in_window(a)) begin
         case (a[7:2])
            6'd0: m_th = d;
            6'd1: n_tl = d;
            6'd2: n_tcon = {ip_set | (m_tcon[2] & d[2]), d[1:0]};
            6'd3: m_led = d[7:0];
            6'd4: m_digi = {16'b0, d[15:0]};
            default: ;
         endcase
      end
      m_tl   = n_tl;
      m_tcon = n_tcon;
   endtask

   task automatic check_outputs();
      logic [3:0] e_an;
      e_an = 4'hF;
      e_an[(m_cyc / SD) % 4] = 1'b0;
      chk("irq", {31'b0, irq}, {31'b0, m_tcon[2]});
      chk("leds", {24'b0, leds}, {24'b0, m_led});
      chk("systick", systick, m_tick);
      chk("digi_an", {28'b0, digi_an}, {28'b0, e_an});
      chk("digi_seg", {24'b0, digi_seg}, {24'b0, m_seg});
   endtask

   // One bus cycle: drive, check combinational outputs, clock, check registered outputs.
   task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      rst = 1'b0; mem_read = r; mem_write = w; addr = a; wdata = d;
      #1;
      chk("hit", {31'b0, hit}, {31'b0, in_window(a)});
      chk("rdata", rdata, r ? model_read(a) : 32'h0);
      model_step(1'b0, w, a, d);
      @(posedge clk);
      #1;
      mem_read = 1'b0; mem_write = 1'b0;
      check_outputs();
      $display("step r=%0b w=%0b addr=%h wdata=%h tl=%h irq=%0b", r, w, a, d, m_tl, irq);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, 1'b1, a, d);
   endtask

   task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
      mem_read = 1'b1; addr = a;
      #1;
      chk(nm, rdata, exp);
      mem_read = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; mem_write = 1'b1; mem_read = 1'b0; addr = 32'h4000_000C; wdata = 32'hFF;
      model_step(1'b1, 1'b1, addr, wdata);
      @(posedge clk);
      #1;
      rst = 1'b0; mem_write = 1'b0;
      check_outputs();
      $display("reset");
   endtask

   initial begin
      logic [3:0] exp_an [4];
      logic [7:0] exp_seg [4];
      logic [3:0] prev_an;
      logic       found;
      logic [31:0] a, d;
      int          sel;

      dec_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_seg = '{8'h8E, 8'hA4, 8'h88, 8'hF9};

      vecs[0]  = '{32'h4000_000C, 32'h0000_00A5, 32'h4000_000C, 32'h0000_00A5};
      vecs[1]  = '{32'h4000_000C, 32'h0000_01FF, 32'h4000_000C, 32'h0000_00FF};
      vecs[2]  = '{32'h4000_0010, 32'h1234_ABCD, 32'h4000_0010, 32'h0000_ABCD};
      vecs[3]  = '{32'h4000_0000, 32'hCAFE_BABE, 32'h4000_0000, 32'hCAFE_BABE};
      vecs[4]  = '{32'h4000_0004, 32'h00C0_FFEE, 32'h4000_0004, 32'h00C0_FFEE};
      vecs[5]  = '{32'h4000_0008, 32'hFFFF_FFFC, 32'h4000_0008, 32'h0000_0000};
      vecs[6]  = '{32'h4000_000F, 32'h0000_003C, 32'h4000_000C, 32'h0000_003C};
      vecs[7]  = '{32'h4000_0020, 32'h0000_DEAD, 32'h4000_0020, 32'h0000_0000};
      vecs[8]  = '{32'h4000_0020, 32'h0000_DEAD, 32'h4000_000C, 32'h0000_003C};
      vecs[9]  = '{32'h1000_000C, 32'h0000_0077, 32'h1000_000C, 32'h0000_0000};
      vecs[10] = '{32'h1000_000C, 32'h0000_0077, 32'h4000_000C, 32'h0000_003C};
      vecs[11] = '{32'h4000_0014, 32'h0000_0000, 32'h4000_0000, 32'hCAFE_BABE};
      vecs[12] = '{32'h4000_0008, 32'h0000_0006, 32'h4000_0008, 32'h0000_0002};

      rst = 1'b1; addr = 0; wdata = 0; mem_read = 0; mem_write = 0;
      do_reset();
      do_reset();

      // reset state after three idle cycles
      idle(); idle(); idle();
      chk("t1_systick", systick, 32'd3);
      chk("t1_an", {28'b0, digi_an}, 32'hE);
      chk("t1_seg", {24'b0, digi_seg}, 32'hC0);
      chk("t1_irq", {31'b0, irq}, 32'h0);
      peek("t1_th", 32'h4000_0000, 32'h0);
      peek("t1_tl", 32'h4000_0004, 32'h0);
      peek("t1_tcon", 32'h4000_0008, 32'h0);
      peek("t1_led", 32'h4000_000C, 32'h0);
      peek("t1_digi", 32'h4000_0010, 32'h0);
      peek("t1_tick", 32'h4000_0014, 32'd3);

      for (int i = 0; i < 13; i++) begin
         wr(vecs[i].wa, vecs[i].wd);
         peek($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
      end

      // timer reload and interrupt clear
      wr(32'h4000_0000, 32'hFFFF_FFFD);
      wr(32'h4000_0004, 32'hFFFF_FFFE);
      wr(32'h4000_0008, 32'h3);
      peek("t2_tl0", 32'h4000_0004, 32'hFFFF_FFFE);
      idle();
      peek("t2_tl1", 32'h4000_0004, 32'hFFFF_FFFF);
      idle();
      peek("t2_tl2", 32'h4000_0004, 32'hFFFF_FFFD);
      chk("t2_irq_set", {31'b0, irq}, 32'h1);
      wr(32'h4000_0008, 32'h3);
      chk("t2_irq_clr", {31'b0, irq}, 32'h0);
      peek("t2_tl3", 32'h4000_0004, 32'hFFFF_FFFE);

      // overflow coincides with a clearing TCON write
      idle();
      peek("t3_tl", 32'h4000_0004, 32'hFFFF_FFFF);
      wr(32'h4000_0008, 32'h3);
      peek("t3_tcon", 32'h4000_0008, 32'h7);
      chk("t3_irq", {31'b0, irq}, 32'h1);
      peek("t3_tl_reload", 32'h4000_0004, 32'hFFFF_FFFD);

      // TL store beats a same-cycle reload
      wr(32'h4000_0008, 32'h3);
      idle();
      peek("t4_tl_max", 32'h4000_0004, 32'hFFFF_FFFF);
      wr(32'h4000_0004, 32'h1234);
      peek("t4_tl_wr", 32'h4000_0004, 32'h1234);
      idle();
      peek("t4_tl_inc", 32'h4000_0004, 32'h1235);
      wr(32'h4000_0008, 32'h0);

      // display scan
      wr(32'h4000_0010, 32'h1A2F);
      prev_an = digi_an;
      found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
         idle();
         if (digi_an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
         prev_an = digi_an;
      end
      chk("t5_slot0_found", {31'b0, found}, 32'h1);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < SD; c++) begin
            chk($sformatf("t5_an_s%0d_c%0d", s, c), {28'b0, digi_an}, {28'b0, exp_an[s]});
            chk($sformatf("t5_seg_s%0d_c%0d", s, c), {24'b0, digi_seg}, {24'b0, exp_seg[s]});
            idle();
         end
      end
      chk("t5_wrap_an", {28'b0, digi_an}, 32'hE);
      chk("t5_wrap_seg", {24'b0, digi_seg}, 32'h8E);

      // random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 8);
         d   = $urandom;
         if (sel <= 5)      a = 32'h4000_0000 | 32'(sel * 4) | 32'($urandom_range(0, 3));
         else if (sel == 6) a = 32'h4000_0000 | 32'(8'h18 + 4 * $urandom_range(0, 57));
         else if (sel == 7) a = 32'h1000_0000 | ($urandom & 32'h0FFF_FFFC);
         else begin
            a = 32'h4000_0004;
            d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         end
         if (sel == 2 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
         step(1'(($urandom >> 3) & 1), 1'($urandom & 1), a, d);
      end

      // reset mid-run with a competing store
      do_reset();
      chk("rst_leds", {24'b0, leds}, 32'h0);
      chk("rst_systick", systick, 32'h0);
      chk("rst_an", {28'b0, digi_an}, 32'hE);
      chk("rst_seg", {24'b0, digi_seg}, 32'hC0);
      peek("rst_tl", 32'h4000_0004, 32'h0);
      peek("rst_tcon", 32'h4000_0008, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
